plab3_mem_l2_req_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one blocking L2 cache (`plab3_mem_BlockingL2Cache`) between the instruction-side requester (port 0) and the data-side requester (port 1). It admits exactly one outstanding transaction at a time, matching the blocking L2. It routes the L2 response back to the port that issued the request. It forwards the originator's `insecure` qualifier for the whole transaction. A watchdog flags transactions that never complete.

---
 rtl/plab3_mem_l2_req_arbiter.sv | 157 +++++++++++++++
 tb/tb_plab3_mem_l2_req_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/plab3_mem_l2_req_arbiter.sv
// plab3_mem_l2_req_arbiter: round-robin two-port front end for the blocking L2.
// One transaction in flight; the response is routed back to its issuing port.
module plab3_mem_l2_req_arbiter #(
  parameter int p_opaque_nbits = 8,
  parameter int abw = 32,
  parameter int clw = 128,
  parameter int p_timeout = 255,
  localparam int LenW = $clog2(clw / 8),
  localparam int ReqW = 3 + p_opaque_nbits + abw + LenW + clw,
  localparam int RespW = 3 + p_opaque_nbits + 2 + LenW + clw
) (
  input  logic             clk,
  input  logic             reset,

  input  logic [ReqW-1:0]  req0_msg,
  input  logic             req0_val,
  output logic             req0_rdy,
  input  logic             req0_insecure,

  input  logic [ReqW-1:0]  req1_msg,
  input  logic             req1_val,
  output logic             req1_rdy,
  input  logic             req1_insecure,

  output logic [RespW-1:0] resp0_msg,
  output logic             resp0_val,
  input  logic             resp0_rdy,

  output logic [RespW-1:0] resp1_msg,
  output logic             resp1_val,
  input  logic             resp1_rdy,

  output logic [ReqW-1:0]  cachereq_msg,
  output logic             cachereq_val,
  input  logic             cachereq_rdy,
  output logic             insecure,

  input  logic [RespW-1:0] cacheresp_msg,
  input  logic             cacheresp_val,
  output logic             cacheresp_rdy,

  output logic             owner,
  output logic             timeout_err
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic        owner_q, owner_d;
  logic        oinsec_q, oinsec_d;
  logic        timeout_q, timeout_d;
  logic [15:0] wd_q, wd_d;

  logic            any_req;
  logic            pref_val;
  logic            grant;
  logic [ReqW-1:0] grant_msg;
  logic            grant_insec;
  logic            own_rdy;

  assign any_req     = req0_val | req1_val;
  assign pref_val    = prio_q ? req1_val : req0_val;
  assign grant       = pref_val ? prio_q : ~prio_q;
  assign grant_msg   = grant ? req1_msg : req0_msg;
  assign grant_insec = grant ? req1_insecure : req0_insecure;
  assign own_rdy     = owner_q ? resp1_rdy : resp0_rdy;

  assign owner       = owner_q;
  assign timeout_err = timeout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      oinsec_q  <= 1'b0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      owner_q   <= owner_d;
      oinsec_q  <= oinsec_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    oinsec_d  = oinsec_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (any_req && cachereq_rdy) begin
          owner_d  = grant;
          oinsec_d = grant_insec;
          wd_d     = '0;
          state_d  = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (cacheresp_val && own_rdy) begin
          state_d = IDLE;
          prio_d  = ~owner_q;
        end else begin
          if (wd_q != 16'hFFFF) wd_d = wd_q + 16'd1;
          if (wd_q == 16'(p_timeout)) timeout_d = 1'b1;
        end
      end
    endcase
  end

  // Outputs forced quiet while reset is held low, whatever the inputs do.
  always_comb begin
    req0_rdy      = 1'b0;
    req1_rdy      = 1'b0;
    resp0_msg     = '0;
    resp0_val     = 1'b0;
    resp1_msg     = '0;
    resp1_val     = 1'b0;
    cachereq_msg  = '0;
    cachereq_val  = 1'b0;
    insecure      = 1'b0;
    cacheresp_rdy = 1'b0;
    if (reset) begin
      unique case (state_q)
        IDLE: begin
          cachereq_msg = grant_msg;
          cachereq_val = any_req;
          insecure     = grant_insec;
          req0_rdy     = ~grant & cachereq_rdy;
          req1_rdy     = grant & cachereq_rdy;
        end
        WAIT_RESP: begin
          insecure      = oinsec_q;
          cacheresp_rdy = own_rdy;
          if (owner_q) begin
            resp1_msg = cacheresp_msg;
            resp1_val = cacheresp_val;
          end else begin
            resp0_msg = cacheresp_msg;
            resp0_val = cacheresp_val;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plab3_mem_l2_req_arbiter.sv
// tb_plab3_mem_l2_req_arbiter: directed checks of the two-port L2 arbiter.
// Watchdog limit set to 4 so the timeout path is reachable quickly.
module tb_plab3_mem_l2_req_arbiter;

  localparam int REQW  = 175;
  localparam int RESPW = 145;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [REQW-1:0]  req0_msg, req1_msg, cachereq_msg;
  logic             req0_val, req1_val, req0_rdy, req1_rdy;
  logic             req0_insecure, req1_insecure;
  logic [RESPW-1:0] resp0_msg, resp1_msg, cacheresp_msg;
  logic             resp0_val, resp1_val, resp0_rdy, resp1_rdy;
  logic             cachereq_val, cachereq_rdy, insecure;
  logic             cacheresp_val, cacheresp_rdy;
  logic             owner, timeout_err;

  int        n_chk = 0;
  int        n_fail = 0;
  logic      prio_m;
  logic      exp_g;
  logic [7:0] opq [2];

  always #5 clk = ~clk;

  plab3_mem_l2_req_arbiter #(
    .p_timeout(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req0_msg(req0_msg),
    .req0_val(req0_val),
    .req0_rdy(req0_rdy),
    .req0_insecure(req0_insecure),
    .req1_msg(req1_msg),
    .req1_val(req1_val),
    .req1_rdy(req1_rdy),
    .req1_insecure(req1_insecure),
    .resp0_msg(resp0_msg),
    .resp0_val(resp0_val),
    .resp0_rdy(resp0_rdy),
    .resp1_msg(resp1_msg),
    .resp1_val(resp1_val),
    .resp1_rdy(resp1_rdy),
    .cachereq_msg(cachereq_msg),
    .cachereq_val(cachereq_val),
    .cachereq_rdy(cachereq_rdy),
    .insecure(insecure),
    .cacheresp_msg(cacheresp_msg),
    .cacheresp_val(cacheresp_val),
    .cacheresp_rdy(cacheresp_rdy),
    .owner(owner),
    .timeout_err(timeout_err)
  );

  function automatic logic [REQW-1:0] mk_req(
    input logic [7:0] o, input logic [31:0] a, input logic [127:0] d);
    return {3'd0, o, a, 4'd0, d};
  endfunction

  function automatic logic [RESPW-1:0] mk_resp(
    input logic [7:0] o, input logic [127:0] d);
    return {3'd0, o, 2'd0, 4'd0, d};
  endfunction

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_msg = '0; req1_msg = '0;
    req0_val = 0; req1_val = 0;
    req0_insecure = 0; req1_insecure = 0;
    resp0_rdy = 0; resp1_rdy = 0;
    cachereq_rdy = 0;
    cacheresp_msg = '0; cacheresp_val = 0;
  endtask

  initial begin
    idle_inputs();
    // outputs stay quiet while reset is held, even with live inputs
    #2;
    req0_val = 1; req0_insecure = 1; cachereq_rdy = 1;
    cacheresp_val = 1; resp0_rdy = 1; resp1_rdy = 1;
    #1;
    check("rst_cachereq_val", cachereq_val, 0);
    check("rst_req_rdy", {req1_rdy, req0_rdy}, 0);
    check("rst_insecure", insecure, 0);
    check("rst_cacheresp_rdy", cacheresp_rdy, 0);
    check("rst_resp_val", {resp1_val, resp0_val}, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_owner", owner, 0);
    idle_inputs();
    step(); step();
    reset = 1;
    step();

    // single port 0 read, L2 answers on the third WAIT cycle
    req0_msg = mk_req(8'h11, 32'h100, 128'h0);
    req0_val = 1; cachereq_rdy = 1;
    #1;
    check("t1_cachereq_val", cachereq_val, 1);
    check("t1_cachereq_msg", cachereq_msg, mk_req(8'h11, 32'h100, 128'h0));
    check("t1_req_rdy", {req1_rdy, req0_rdy}, 2'b01);
    step();
    req0_val = 0;
    #1;
    check("t1_wait_req_rdy", {req1_rdy, req0_rdy}, 0);
    check("t1_wait_cachereq_val", cachereq_val, 0);
    check("t1_owner", owner, 0);
    check("t1_resp_quiet", {resp1_val, resp0_val}, 0);
    step(); step();
    cachereq_rdy = 0;
    cacheresp_msg = mk_resp(8'h11, 128'hCAFE_0000_BEEF);
    cacheresp_val = 1; resp0_rdy = 1;
    #1;
    check("t1_resp0_val", resp0_val, 1);
    check("t1_resp0_msg", resp0_msg, mk_resp(8'h11, 128'hCAFE_0000_BEEF));
    check("t1_resp1_val", resp1_val, 0);
    check("t1_resp1_msg", resp1_msg, 0);
    check("t1_cacheresp_rdy", cacheresp_rdy, 1);
    step();
    cacheresp_val = 0; resp0_rdy = 0;
    req0_msg = mk_req(8'h20, 32'h200, 128'h1);
    req1_msg = mk_req(8'h21, 32'h204, 128'h2);
    req0_val = 1; req1_val = 1;
    #1;
    check("t1_prio_flip", cachereq_msg, mk_req(8'h21, 32'h204, 128'h2));
    idle_inputs();
    step();

    // both ports busy from reset: round-robin plus insecure tracking
    #1; reset = 0; #1; reset = 1;
    step();
    prio_m = 0;
    opq[0] = 8'h40; opq[1] = 8'h80;
    for (int i = 0; i < 4; i++) begin
      req0_insecure = 0; req1_insecure = 1;
      req0_msg = mk_req(opq[0], 32'h1000, 128'hA0);
      req1_msg = mk_req(opq[1], 32'h2000, 128'hB0);
      req0_val = 1; req1_val = 1; cachereq_rdy = 1;
      exp_g = prio_m;
      #1;
      check("t2_issue_msg", cachereq_msg, exp_g ?
            mk_req(opq[1], 32'h2000, 128'hB0) :
            mk_req(opq[0], 32'h1000, 128'hA0));
      check("t2_req_rdy", {req1_rdy, req0_rdy}, exp_g ? 2'b10 : 2'b01);
      step();
      req0_insecure = 1; req1_insecure = 0;
      #1;
      check("t2_owner", owner, exp_g);
      check("t2_wait_rdy", {req1_rdy, req0_rdy}, 0);
      check("t3_insecure_w1", insecure, exp_g);
      step();
      req0_insecure = 0; req1_insecure = 1;
      cacheresp_msg = mk_resp(opq[exp_g], 128'(32'hD0 + i));
      cacheresp_val = 1; resp0_rdy = 1; resp1_rdy = 1;
      #1;
      check("t3_insecure_w2", insecure, exp_g);
      check("t2_resp_val", {resp1_val, resp0_val}, exp_g ? 2'b10 : 2'b01);
      check("t2_resp_msg", exp_g ? resp1_msg : resp0_msg,
            mk_resp(opq[exp_g], 128'(32'hD0 + i)));
      check("t2_other_msg", exp_g ? resp0_msg : resp1_msg, 0);
      step();
      cacheresp_val = 0;
      opq[exp_g] = opq[exp_g] + 8'd1;
      prio_m = ~exp_g;
    end
    idle_inputs();

    // owner back-pressure: response held until resp0_rdy rises
    req0_msg = mk_req(8'h55, 32'h300, 128'h3);
    req0_val = 1; cachereq_rdy = 1;
    step();
    req0_val = 0; cachereq_rdy = 0;
    req1_msg = mk_req(8'h66, 32'h400, 128'h4); req1_val = 1;
    cacheresp_msg = mk_resp(8'h55, 128'h1234_5678);
    cacheresp_val = 1; resp0_rdy = 0; resp1_rdy = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t4_cacheresp_rdy", cacheresp_rdy, 0);
      check("t4_still_wait", cachereq_val, 0);
      step();
    end
    resp0_rdy = 1;
    #1;
    check("t4_cacheresp_rdy_up", cacheresp_rdy, 1);
    check("t4_resp0_msg", resp0_msg, mk_resp(8'h55, 128'h1234_5678));
    check("t4_resp1_val", resp1_val, 0);
    step();
    cacheresp_val = 0;
    #1;
    check("t4_back_idle", cachereq_val, 1);
    check("t4_timeout_sticky", timeout_err, 1);
    idle_inputs();

    // watchdog: reset clears it, then it trips when L2 stays silent
    #1; reset = 0; #1; reset = 1;
    #1;
    check("t5_err_cleared", timeout_err, 0);
    step();
    req0_msg = mk_req(8'h77, 32'h500, 128'h5);
    req0_val = 1; req0_insecure = 1; cachereq_rdy = 1;
    step();
    req0_val = 0; req0_insecure = 0; cachereq_rdy = 0;
    step(); step(); step();
    check("t5_err_early", timeout_err, 0);
    step(); step(); step();
    check("t5_err_set", timeout_err, 1);
    step(); step();
    check("t5_err_hold", timeout_err, 1);
    check("t5_insecure_owner", insecure, 1);

    // asynchronous reset in WAIT_RESP, then a fresh request
    cacheresp_msg = mk_resp(8'h77, 128'h9); cacheresp_val = 1;
    resp0_rdy = 1; req0_val = 1; cachereq_rdy = 1;
    #1; reset = 0; #1;
    check("t6_err", timeout_err, 0);
    check("t6_resp_val", {resp1_val, resp0_val}, 0);
    check("t6_cacheresp_rdy", cacheresp_rdy, 0);
    check("t6_insecure", insecure, 0);
    check("t6_cachereq_val", cachereq_val, 0);
    check("t6_req_rdy", {req1_rdy, req0_rdy}, 0);
    cacheresp_val = 0; resp0_rdy = 0;
    req0_msg = mk_req(8'h88, 32'h600, 128'h6);
    #1; reset = 1; #1;
    check("t6_post_rdy", {req1_rdy, req0_rdy}, 2'b01);
    check("t6_post_msg", cachereq_msg, mk_req(8'h88, 32'h600, 128'h6));
    step();
    req0_val = 0; cachereq_rdy = 0;
    #1;
    check("t6_post_wait", cachereq_val, 0);
    check("t6_post_owner", owner, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
